// File: rtl/seq_shifter_if.sv
// Request/response bundle for seq_shifter: valid/ready request in, valid/ready result out.
interface seq_shifter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic [SHW-1:0]   shamt;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             busy;

  modport master (
    output in_valid, din, shamt, op, out_ready,
    input  in_ready, out_valid, dout, busy
  );

  modport slave (
    input  in_valid, din, shamt, op, out_ready,
    output in_ready, out_valid, dout, busy
  );
endinterface

// File: rtl/seq_shifter.sv
// Sequential shifter, one bit position per clock: SLL/SRL/SRA, plus ROR when
// SEQ_SHF_ROT_EN is defined (otherwise op 11 behaves as SRL).
module seq_shifter #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  seq_shifter_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc, acc_nxt, dout_q;
  logic [SHW-1:0]   cnt;
  logic [1:0]       opr;
  logic             out_valid_q, busy_q;

  // One-bit step for the latched operation.
  always_comb begin
    acc_nxt = {1'b0, acc[WIDTH-1:1]};
    case (opr)
      2'b00:   acc_nxt = {acc[WIDTH-2:0], 1'b0};
      2'b10:   acc_nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
`ifdef SEQ_SHF_ROT_EN
      2'b11:   acc_nxt = {acc[0], acc[WIDTH-1:1]};
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      opr         <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          acc    <= bus.din;
          cnt    <= bus.shamt;
          opr    <= bus.op;
          busy_q <= 1'b1;
          if (bus.shamt == '0) begin
            state       <= DONE;
            dout_q      <= bus.din;
            out_valid_q <= 1'b1;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= acc_nxt;
          cnt <= cnt - SHW'(1);
          // Last step: publish the shifted value directly so dout is valid with out_valid.
          if (cnt == SHW'(1)) begin
            state       <= DONE;
            dout_q      <= acc_nxt;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: directed vector table, reset/abort sequences, and
// random operations checked against an arithmetic reference model.
module tb_seq_shifter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  seq_shifter_if #(.WIDTH(W)) bus ();
  seq_shifter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [4:0]  sh;
    logic [1:0]  op;
    logic [31:0] exp;
    int          stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference: plain shift operators on the operand as a whole.
  function automatic logic [31:0] model(input logic [31:0] x, input int s, input logic [1:0] op);
    logic signed [31:0] sx;
    sx = x;
    case (op)
      2'b00: return x << s;
      2'b10: return 32'(sx >>> s);
`ifdef SEQ_SHF_ROT_EN
      2'b11: return (s == 0) ? x : ((x >> s) | (x << (32 - s)));
`endif
      default: return x >> s;
    endcase
  endfunction

  // Issue one request, check latency, result, stall behaviour and return to idle.
  task automatic run(input logic [31:0] din, input logic [4:0] sh, input logic [1:0] op,
                     input logic [31:0] exp, input int stall, input string name);
    int   lat;
    logic ok;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.din       = din;
    bus.shamt     = sh;
    bus.op        = op;
    bus.out_ready = (stall == 0);
    #1 chk({name, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    lat = 1;
    ok  = 1'b1;
    // Keep in_valid high with junk operands while busy: must be ignored.
    while (!bus.out_valid && lat <= W + 4) begin
      bus.din   = $urandom;
      bus.shamt = 5'($urandom);
      bus.op    = 2'($urandom);
      if (!bus.busy || bus.in_ready) ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    chk({name, ".busy_shift"}, 32'(ok), 32'd1);
    chk({name, ".latency"}, 32'(lat), 32'(sh) + 32'd1);
    chk({name, ".dout"}, bus.dout, exp);
    if (stall > 0) begin
      ok = 1'b1;
      repeat (stall) begin
        if (!(bus.out_valid && bus.dout === exp && !bus.in_ready && bus.busy)) ok = 1'b0;
        @(negedge clk);
      end
      chk({name, ".stall_hold"}, 32'(ok), 32'd1);
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    chk({name, ".idle"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
  endtask

  vec_t vecs[$];
  logic saw_ov;
  logic [31:0] rd;
  logic [4:0]  rs;
  logic [1:0]  ro;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.din = '0; bus.shamt = '0; bus.op = '0; bus.out_ready = 1'b1;

    // Power-on reset.
    repeat (2) @(negedge clk);
    chk("por.in_ready_in_rst", 32'(bus.in_ready), 32'd0);
    chk("por.out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("por.release", {bus.dout[29:0] != 30'd0, bus.busy, bus.in_ready}, 32'd1);

    vecs = '{
      '{32'h80000010, 5'd4,  2'b10, 32'hF8000001, 0},
      '{32'h80000000, 5'd0,  2'b01, 32'h80000000, 0},
      '{32'h00000001, 5'd31, 2'b00, 32'h80000000, 0},
      '{32'hFFFF0000, 5'd8,  2'b01, 32'h00FFFF00, 10},
`ifdef SEQ_SHF_ROT_EN
      '{32'h00000001, 5'd1,  2'b11, 32'h80000000, 0},
`else
      '{32'h00000001, 5'd1,  2'b11, 32'h00000000, 0},
`endif
      '{32'h12345678, 5'd4,  2'b00, 32'h23456780, 0},
      '{32'h7FFFFFFF, 5'd31, 2'b10, 32'h00000000, 0},
      '{32'hFFFFFFFF, 5'd31, 2'b10, 32'hFFFFFFFF, 2},
      '{32'hDEADBEEF, 5'd16, 2'b01, 32'h0000DEAD, 0}
    };
    foreach (vecs[i])
      run(vecs[i].din, vecs[i].sh, vecs[i].op, vecs[i].exp, vecs[i].stall, $sformatf("vec%0d", i));

    // Reset held 3 cycles in the middle of a long shift.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.din = 32'hA5A5A5A5; bus.shamt = 5'd30; bus.op = 2'b01;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    saw_ov = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.in_ready || bus.out_valid) saw_ov = 1'b1;
    end
    chk("rst3.during", 32'(saw_ov), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst3.after", {bus.dout, 32'(0)} == {32'd0, 32'd0} ? {29'd0, bus.out_valid, bus.busy, bus.in_ready} : 32'hDEAD,
        32'd1);

    // Abort: reset in the 5th SHIFT cycle of SLL by 20.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.din = 32'h0000F00D; bus.shamt = 5'd20; bus.op = 2'b00;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    saw_ov = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) saw_ov = 1'b1;
    end
    chk("abort.no_out_valid", 32'(saw_ov), 32'd0);
    run(32'h00000003, 5'd1, 2'b00, 32'h00000006, 0, "abort.next");

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rd = $urandom;
      rs = 5'($urandom);
      ro = 2'($urandom);
      run(rd, rs, ro, model(rd, int'(rs), ro), int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
